// File: rtl/line_scheduler.sv
// Frame/line sequencer for a 64-cycle line timer: drives the timer enable, counts lines
// and frames, issues start strobes and blanking flags, and supports graceful stop and abort.
module line_scheduler #(
  parameter int unsigned LINES_PER_FRAME = 525,
  parameter int unsigned VBLANK_LINES    = 45,
  parameter int unsigned LCNT_W          = 10
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              stop,
  input  logic              abort,
  input  logic              line_end,
  output logic              en_line_timer,
  output logic              line_start,
  output logic              frame_start,
  output logic              frame_done,
  output logic              vblank,
  output logic              active,
  output logic              busy,
  output logic [LCNT_W-1:0] line_cnt,
  output logic [15:0]       frame_cnt
);

  localparam logic [LCNT_W-1:0] LAST_LINE = LCNT_W'(LINES_PER_FRAME - 1);
  localparam logic [LCNT_W-1:0] VBL_LINES = LCNT_W'(VBLANK_LINES);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t              state_q, state_d;
  logic                stop_pend_q, stop_pend_d;
  logic [LCNT_W-1:0]   line_cnt_q, line_cnt_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic                en_q, en_d;
  logic                line_start_q, line_start_d;
  logic                frame_start_q, frame_start_d;
  logic                frame_done_q, frame_done_d;
  logic                vblank_q, vblank_d;
  logic                active_q, active_d;
  logic                busy_q, busy_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      stop_pend_q   <= 1'b0;
      line_cnt_q    <= '0;
      frame_cnt_q   <= '0;
      en_q          <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      vblank_q      <= 1'b0;
      active_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      stop_pend_q   <= stop_pend_d;
      line_cnt_q    <= line_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      en_q          <= en_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      vblank_q      <= vblank_d;
      active_q      <= active_d;
      busy_q        <= busy_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    stop_pend_d   = stop_pend_q;
    line_cnt_d    = line_cnt_q;
    frame_cnt_d   = frame_cnt_q;
    en_d          = en_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d       = S_RUN;
          en_d          = 1'b1;
          line_cnt_d    = '0;
          line_start_d  = 1'b1;
          frame_start_d = 1'b1;
          stop_pend_d   = 1'b0;
        end
      end
      S_RUN: begin
        en_d = 1'b1;
        if (abort) begin
          // Abort wins over stop and swallows a coincident line_end
          state_d = S_FLUSH;
        end else begin
          if (stop) stop_pend_d = 1'b1;
          if (line_end) begin
            if (line_cnt_q != LAST_LINE) begin
              line_cnt_d   = line_cnt_q + LCNT_W'(1);
              line_start_d = 1'b1;
            end else begin
              frame_done_d = 1'b1;
              frame_cnt_d  = frame_cnt_q + 16'd1;
              if (stop_pend_q || stop) begin
                state_d     = S_IDLE;
                en_d        = 1'b0;
                stop_pend_d = 1'b0;
              end else begin
                line_cnt_d    = '0;
                line_start_d  = 1'b1;
                frame_start_d = 1'b1;
              end
            end
          end
        end
      end
      S_FLUSH: begin
        // Keep the timer enabled until it wraps to 0, then release it
        en_d = 1'b1;
        if (line_end) begin
          state_d     = S_IDLE;
          en_d        = 1'b0;
          stop_pend_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        en_d    = 1'b0;
      end
    endcase

    busy_d   = (state_d != S_IDLE);
    vblank_d = (state_d == S_RUN) && (line_cnt_d < VBL_LINES);
    active_d = (state_d == S_RUN) && (line_cnt_d >= VBL_LINES);
  end

  assign en_line_timer = en_q;
  assign line_start    = line_start_q;
  assign frame_start   = frame_start_q;
  assign frame_done    = frame_done_q;
  assign vblank        = vblank_q;
  assign active        = active_q;
  assign busy          = busy_q;
  assign line_cnt      = line_cnt_q;
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_line_scheduler.sv
// Bench for line_scheduler with a 64-cycle line timer model, an elapsed-time reference
// model checked every cycle, and directed scenarios with literal expectations.
module tb_line_scheduler;

  localparam int LPF   = 4;
  localparam int VBL   = 1;
  localparam int LW    = 10;
  localparam int LINE  = 64;
  localparam int FRAME = LINE * LPF;

  logic          clk, resetn, start, stop, abort, line_end;
  logic          en_line_timer, line_start, frame_start, frame_done, vblank, active, busy;
  logic [LW-1:0] line_cnt;
  logic [15:0]   frame_cnt;
  logic [5:0]    tcnt;

  int vectors = 0;
  int miscompares = 0;

  line_scheduler #(.LINES_PER_FRAME(LPF), .VBLANK_LINES(VBL), .LCNT_W(LW)) dut (
    .clk(clk), .resetn(resetn), .start(start), .stop(stop), .abort(abort),
    .line_end(line_end), .en_line_timer(en_line_timer), .line_start(line_start),
    .frame_start(frame_start), .frame_done(frame_done), .vblank(vblank),
    .active(active), .busy(busy), .line_cnt(line_cnt), .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Line timer: free-running 0..63 while enabled
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) tcnt <= 6'd0;
    else if (en_line_timer) tcnt <= tcnt + 6'd1;
  end
  assign line_end = (tcnt == 6'd63);

  // Reference model: elapsed cycles k since start determine everything while running
  int m_mode, m_k, m_base, m_line_h, m_frames_h;
  bit m_sp, m_done;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_mode <= 0; m_k <= 0; m_base <= 0; m_line_h <= 0; m_frames_h <= 0;
      m_sp <= 1'b0; m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      case (m_mode)
        0: if (start) begin
          m_mode <= 1; m_k <= 0; m_base <= m_frames_h; m_sp <= 1'b0;
        end
        1: if (abort) begin
          m_mode <= 2;
          m_line_h <= (m_k / LINE) % LPF;
          m_frames_h <= m_base + m_k / FRAME;
          m_k <= m_k + 1;
        end else if ((m_k % FRAME == FRAME - 1) && (m_sp || stop)) begin
          m_mode <= 0;
          m_line_h <= LPF - 1;
          m_frames_h <= m_base + (m_k + 1) / FRAME;
          m_done <= 1'b1;
        end else begin
          m_k <= m_k + 1;
          if (stop) m_sp <= 1'b1;
        end
        default: begin
          if (m_k % LINE == LINE - 1) m_mode <= 0;
          m_k <= m_k + 1;
        end
      endcase
    end
  end

  function automatic logic [38:0] model_exp();
    logic       e_en, e_ls, e_fs, e_fd, e_vb, e_act, e_busy;
    int         e_line, e_frames, e_t;
    e_en = 0; e_ls = 0; e_fs = 0; e_fd = 0; e_vb = 0; e_act = 0; e_busy = 0;
    e_line = m_line_h; e_frames = m_frames_h; e_t = 0;
    if (m_mode == 0) begin
      e_fd = m_done;
    end else if (m_mode == 1) begin
      e_en = 1; e_busy = 1;
      e_ls = (m_k % LINE == 0);
      e_fs = (m_k % FRAME == 0);
      e_fd = e_fs && (m_k > 0);
      e_line = (m_k / LINE) % LPF;
      e_frames = m_base + m_k / FRAME;
      e_vb = (e_line < VBL);
      e_act = !e_vb;
      e_t = m_k % LINE;
    end else begin
      e_en = 1; e_busy = 1;
      e_t = m_k % LINE;
    end
    return {e_en, e_ls, e_fs, e_fd, e_vb, e_act, e_busy, LW'(e_line), 16'(e_frames), 6'(e_t)};
  endfunction

  always @(negedge clk) begin
    logic [38:0] act, exp;
    act = {en_line_timer, line_start, frame_start, frame_done, vblank, active, busy,
           line_cnt, frame_cnt, tcnt};
    exp = model_exp();
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL cycle_model t=%0t k=%0d act=%h exp=%h", $time, m_k, act, exp);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_line_start(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!line_start && n < 100);
  endtask

  initial begin
    int n;
    resetn = 1'b0; start = 1'b0; stop = 1'b0; abort = 1'b0;
    repeat (5) begin
      @(negedge clk);
      start = ~start; stop = ~stop; abort = ~abort;
    end
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_en", 32'(en_line_timer), 32'd0);
    start = 1'b0; stop = 1'b0; abort = 1'b0;
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // Continuous frames
    pulse_start();
    check("start_ls", 32'(line_start), 32'd1);
    check("start_fs", 32'(frame_start), 32'd1);
    check("start_vblank", 32'(vblank), 32'd1);
    repeat (64) @(negedge clk);
    check("line1_cnt", 32'(line_cnt), 32'd1);
    check("line1_active", 32'(active), 32'd1);
    repeat (448) @(negedge clk);
    check("k512_frames", 32'(frame_cnt), 32'd2);
    check("k512_fd", 32'(frame_done), 32'd1);

    // Graceful stop during line 1
    repeat (64) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_idle(n);
    check("stop_wait", 32'(n), 32'd191);
    check("stop_fd", 32'(frame_done), 32'd1);
    check("stop_line", 32'(line_cnt), 32'd3);
    check("stop_frames", 32'(frame_cnt), 32'd3);
    check("stop_tcnt", 32'(tcnt), 32'd0);

    // Restart, then abort (with stop) 10 cycles into line 2
    repeat (2) @(negedge clk);
    pulse_start();
    wait_line_start(n);
    check("first_line_len", 32'(n), 32'd64);
    repeat (74) @(negedge clk);
    abort = 1'b1; stop = 1'b1;
    @(negedge clk);
    abort = 1'b0; stop = 1'b0;
    check("flush_vblank", 32'(vblank | active), 32'd0);
    check("flush_en", 32'(en_line_timer), 32'd1);
    wait_idle(n);
    check("flush_len", 32'(n), 32'd53);
    check("abort_line", 32'(line_cnt), 32'd2);
    check("abort_frames", 32'(frame_cnt), 32'd3);
    check("abort_tcnt", 32'(tcnt), 32'd0);

    // stop/abort ignored in IDLE
    stop = 1'b1; abort = 1'b1;
    @(negedge clk);
    stop = 1'b0; abort = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_ignore", 32'(busy), 32'd0);

    // start while busy ignored; stop on the last line_end ends immediately
    pulse_start();
    repeat (30) @(negedge clk);
    pulse_start();
    repeat (224) @(negedge clk);
    check("last_line", 32'(line_cnt), 32'd3);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("late_stop_busy", 32'(busy), 32'd0);
    check("late_stop_fd", 32'(frame_done), 32'd1);
    check("late_stop_frames", 32'(frame_cnt), 32'd4);

    // Asynchronous reset in line 2
    repeat (2) @(negedge clk);
    pulse_start();
    repeat (140) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("areset_busy", 32'(busy), 32'd0);
    check("areset_en", 32'(en_line_timer), 32'd0);
    check("areset_line", 32'(line_cnt), 32'd0);
    check("areset_frames", 32'(frame_cnt), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    pulse_start();
    wait_line_start(n);
    check("post_reset_line_len", 32'(n), 32'd64);
    repeat (192) @(negedge clk);
    check("post_reset_frames", 32'(frame_cnt), 32'd1);
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
